axi_lite_mem32_pattern_master: RTL and testbench

Self-checking AXI4-Lite master that sits directly upstream of the 32-bit AXI-Lite test memory and drives its slave port. On a start pulse it writes a seeded pseudo-random pattern across a word range, reads the range back, and compares each word. It reports pass/fail, an error count and the first failing address, so the memory path can be exercised in hardware without host traffic.

---
 rtl/axi_lite_mem32_pattern_master_if.sv | 32 +++
 rtl/axi_lite_mem32_pattern_master.sv | 218 +++++++++++++++++++++
 tb/tb_axi_lite_mem32_pattern_master.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_mem32_pattern_master_if.sv
// AXI4-Lite bus bundle between the pattern master and the test memory slave port.
interface axi_lite_mem32_pattern_master_if #(
  parameter int unsigned ADDR_W = 24
);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_mem32_pattern_master.sv
// Write/read-back pattern tester for a 32-bit AXI4-Lite memory, one transaction in flight.
module axi_lite_mem32_pattern_master #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned BASE      = 0,
  parameter int unsigned NUM_WORDS = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic [31:0]       io_seed,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_pass,
  output logic [15:0]       io_errCount,
  output logic [ADDR_W-1:0] io_firstErrAddr,
  axi_lite_mem32_pattern_master_if.master io_axi
);

  localparam int unsigned   IDX_W    = 16;
  localparam int unsigned   CNT_W    = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [31:0]   GOLDEN   = 32'h9E3779B9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Byte address of word idx; wraps at ADDR_W bits.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] idx);
    return ADDR_W'(BASE) + ADDR_W'({idx, 2'b00});
  endfunction

  // Pattern word for index idx under the given seed.
  function automatic logic [31:0] data_of(input logic [IDX_W-1:0] idx, input logic [31:0] seed);
    return seed ^ (32'(idx) * GOLDEN);
  endfunction

  state_t            r_state,    w_state;
  logic [IDX_W-1:0]  r_idx,      w_idx;
  logic [31:0]       r_seed,     w_seed;
  logic [CNT_W-1:0]  r_err_cnt,  w_err_cnt;
  logic [ADDR_W-1:0] r_first_err, w_first_err;
  logic [ADDR_W-1:0] r_awaddr,   w_awaddr;
  logic              r_awvalid,  w_awvalid;
  logic [31:0]       r_wdata,    w_wdata;
  logic              r_wvalid,   w_wvalid;
  logic              r_bready,   w_bready;
  logic [ADDR_W-1:0] r_araddr,   w_araddr;
  logic              r_arvalid,  w_arvalid;
  logic              r_rready,   w_rready;
  logic              r_busy,     w_busy;
  logic              r_done,     w_done;
  logic              r_pass,     w_pass;
  logic              w_err;
  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_last;
  logic [IDX_W-1:0]  w_idx_inc;

  assign w_aw_hs   = r_awvalid & io_axi.awready;
  assign w_w_hs    = r_wvalid & io_axi.wready;
  assign w_last    = (r_idx == LAST_IDX);
  assign w_idx_inc = r_idx + IDX_W'(1);

  // Next-state, next-output and error bookkeeping.
  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_seed      = r_seed;
    w_err_cnt   = r_err_cnt;
    w_first_err = r_first_err;
    w_awaddr    = r_awaddr;
    w_awvalid   = r_awvalid;
    w_wdata     = r_wdata;
    w_wvalid    = r_wvalid;
    w_bready    = r_bready;
    w_araddr    = r_araddr;
    w_arvalid   = r_arvalid;
    w_rready    = r_rready;
    w_err       = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (io_start) begin
          w_seed      = io_seed;
          w_idx       = '0;
          w_err_cnt   = '0;
          w_first_err = '0;
          w_awaddr    = addr_of('0);
          w_wdata     = data_of('0, io_seed);
          w_awvalid   = 1'b1;
          w_wvalid    = 1'b1;
          w_state     = WADDR;
        end
      end
      WADDR: begin
        if (w_aw_hs) w_awvalid = 1'b0;
        if (w_w_hs)  w_wvalid  = 1'b0;
        if (!w_awvalid && !w_wvalid) begin
          w_bready = 1'b1;
          w_state  = WRESP;
        end
      end
      WRESP: begin
        if (io_axi.bvalid) begin
          w_bready = 1'b0;
          w_err    = (io_axi.bresp != 2'b00);
          if (w_last) begin
            w_idx     = '0;
            w_araddr  = addr_of('0);
            w_arvalid = 1'b1;
            w_state   = RADDR;
          end else begin
            w_idx     = w_idx_inc;
            w_awaddr  = addr_of(w_idx_inc);
            w_wdata   = data_of(w_idx_inc, r_seed);
            w_awvalid = 1'b1;
            w_wvalid  = 1'b1;
            w_state   = WADDR;
          end
        end
      end
      RADDR: begin
        if (io_axi.arready) begin
          w_arvalid = 1'b0;
          w_rready  = 1'b1;
          w_state   = RDATA;
        end
      end
      RDATA: begin
        if (io_axi.rvalid) begin
          w_rready = 1'b0;
          w_err    = (io_axi.rresp != 2'b00) || (io_axi.rdata != data_of(r_idx, r_seed));
          if (w_last) begin
            w_state = DONE;
          end else begin
            w_idx     = w_idx_inc;
            w_araddr  = addr_of(w_idx_inc);
            w_arvalid = 1'b1;
            w_state   = RADDR;
          end
        end
      end
      default: w_state = IDLE;
    endcase

    // At most one error per cycle; count saturates, first address is sticky.
    if (w_err) begin
      if (r_err_cnt != {CNT_W{1'b1}}) w_err_cnt = r_err_cnt + CNT_W'(1);
      if (r_err_cnt == '0)            w_first_err = addr_of(r_idx);
    end

    w_busy = (w_state == WADDR) || (w_state == WRESP) || (w_state == RADDR) || (w_state == RDATA);
    w_done = (w_state == DONE);
    w_pass = (w_state == DONE) && (w_err_cnt == '0);
  end

  // State and registered outputs; reset abandons any pending transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_seed      <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_seed      <= w_seed;
      r_err_cnt   <= w_err_cnt;
      r_first_err <= w_first_err;
      r_awaddr    <= w_awaddr;
      r_awvalid   <= w_awvalid;
      r_wdata     <= w_wdata;
      r_wvalid    <= w_wvalid;
      r_bready    <= w_bready;
      r_araddr    <= w_araddr;
      r_arvalid   <= w_arvalid;
      r_rready    <= w_rready;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_pass      <= w_pass;
    end
  end

  assign io_axi.awaddr  = r_awaddr;
  assign io_axi.awvalid = r_awvalid;
  assign io_axi.wdata   = r_wdata;
  assign io_axi.wstrb   = 4'hF;
  assign io_axi.wvalid  = r_wvalid;
  assign io_axi.bready  = r_bready;
  assign io_axi.araddr  = r_araddr;
  assign io_axi.arvalid = r_arvalid;
  assign io_axi.rready  = r_rready;

  assign io_busy         = r_busy;
  assign io_done         = r_done;
  assign io_pass         = r_pass;
  assign io_errCount     = r_err_cnt;
  assign io_firstErrAddr = r_first_err;

endmodule

// File: tb/tb_axi_lite_mem32_pattern_master.sv
// Bench for the pattern master: AXI-Lite memory slave model stepped on the falling edge,
// expected AW/W/AR payloads queued at start and popped at each handshake.
module tb_axi_lite_mem32_pattern_master;

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned NW      = 4;
  localparam int unsigned TIMEOUT = 2000;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [31:0]       seed_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic [15:0]       err_cnt;
  logic [ADDR_W-1:0] first_err;

  axi_lite_mem32_pattern_master_if #(.ADDR_W(ADDR_W)) axi ();

  axi_lite_mem32_pattern_master #(
    .ADDR_W    (ADDR_W),
    .BASE      (0),
    .NUM_WORDS (NW)
  ) dut (
    .clock           (clk),
    .reset           (rst),
    .io_start        (start),
    .io_seed         (seed_in),
    .io_busy         (busy),
    .io_done         (done),
    .io_pass         (pass),
    .io_errCount     (err_cnt),
    .io_firstErrAddr (first_err),
    .io_axi          (axi.master)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] exp_aw_q[$];
  logic [31:0]       exp_w_q[$];
  logic [ADDR_W-1:0] exp_ar_q[$];
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;

  logic [31:0] mem [16];

  bit                stall_en;
  bit                corrupt_en, bresp_err_en, rresp_err_en;
  logic [ADDR_W-1:0] corrupt_addr, bresp_err_addr, rresp_err_addr;

  bit                got_aw, got_w, wr_active, rd_active, b_armed, r_pend;
  int unsigned       aw_wait, w_wait, ar_wait, b_wait, r_wait;
  bit                hs_aw, hs_w, hs_b, hs_ar, hs_r;
  logic [ADDR_W-1:0] hs_awaddr, hs_araddr, aw_addr_l, ar_addr_l;
  logic [31:0]       hs_wdata, w_data_l;
  logic [3:0]        hs_wstrb;
  bit                prev_awv, prev_wv, prev_arv;
  logic [ADDR_W-1:0] prev_awaddr, prev_araddr;
  logic [31:0]       prev_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] seed, input int unsigned i);
    return seed ^ (32'(i) * 32'h9E3779B9);
  endfunction

  function automatic int unsigned draw_wait();
    return stall_en ? $urandom_range(0, 5) : 0;
  endfunction

  // One falling-edge step of the memory slave: retire handshakes from the last rising edge,
  // check payload stability, then drive ready/valid for the next rising edge.
  task automatic slave_step();
    if (rst) begin
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
      got_aw = 0; got_w = 0; wr_active = 0; rd_active = 0; b_armed = 0; r_pend = 0;
      hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
      prev_awv = 0; prev_wv = 0; prev_arv = 0;
      return;
    end

    if (hs_aw) begin
      aw_cnt++; got_aw = 1; aw_addr_l = hs_awaddr;
      check("aw_expected", 64'(exp_aw_q.size() != 0), 64'd1);
      if (exp_aw_q.size() != 0) check("awaddr", 64'(hs_awaddr), 64'(exp_aw_q.pop_front()));
    end
    if (hs_w) begin
      w_cnt++; got_w = 1; w_data_l = hs_wdata;
      check("wstrb", 64'(hs_wstrb), 64'hF);
      check("w_expected", 64'(exp_w_q.size() != 0), 64'd1);
      if (exp_w_q.size() != 0) check("wdata", 64'(hs_wdata), 64'(exp_w_q.pop_front()));
    end
    if (hs_b) begin
      b_cnt++; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      got_aw = 0; got_w = 0; wr_active = 0; b_armed = 0;
    end
    if (hs_ar) begin
      ar_cnt++; ar_addr_l = hs_araddr; r_pend = 1; r_wait = draw_wait();
      check("ar_expected", 64'(exp_ar_q.size() != 0), 64'd1);
      if (exp_ar_q.size() != 0) check("araddr", 64'(hs_araddr), 64'(exp_ar_q.pop_front()));
    end
    if (hs_r) begin
      r_cnt++; axi.rvalid = 1'b0; axi.rresp = 2'b00; rd_active = 0;
    end

    if (prev_awv && !hs_aw) check("aw_hold", 64'({axi.awvalid, axi.awaddr}), 64'({1'b1, prev_awaddr}));
    if (prev_wv && !hs_w)   check("w_hold",  64'({axi.wvalid, axi.wdata}),   64'({1'b1, prev_wdata}));
    if (prev_arv && !hs_ar) check("ar_hold", 64'({axi.arvalid, axi.araddr}), 64'({1'b1, prev_araddr}));

    if ((axi.awvalid || axi.wvalid) && !wr_active) begin
      wr_active = 1;
      aw_wait   = draw_wait();
      w_wait    = stall_en ? (aw_wait + 1 + $urandom_range(0, 4)) % 6 : 0;
    end
    if (axi.arvalid && !rd_active) begin
      rd_active = 1;
      ar_wait   = draw_wait();
    end

    axi.awready = 1'b0;
    if (axi.awvalid && !got_aw) begin
      if (aw_wait == 0) axi.awready = 1'b1; else aw_wait--;
    end
    axi.wready = 1'b0;
    if (axi.wvalid && !got_w) begin
      if (w_wait == 0) axi.wready = 1'b1; else w_wait--;
    end
    axi.arready = 1'b0;
    if (axi.arvalid && !r_pend && !axi.rvalid) begin
      if (ar_wait == 0) axi.arready = 1'b1; else ar_wait--;
    end

    if (got_aw && got_w && !axi.bvalid) begin
      if (!b_armed) begin b_armed = 1; b_wait = draw_wait(); end
      if (b_wait == 0) begin
        axi.bvalid = 1'b1;
        axi.bresp  = (bresp_err_en && aw_addr_l == bresp_err_addr) ? 2'b10 : 2'b00;
        mem[aw_addr_l[5:2]] = w_data_l;
      end else b_wait--;
    end

    if (r_pend) begin
      if (r_wait == 0) begin
        r_pend     = 0;
        axi.rvalid = 1'b1;
        axi.rdata  = mem[ar_addr_l[5:2]];
        axi.rresp  = 2'b00;
        if (corrupt_en && ar_addr_l == corrupt_addr) axi.rdata = axi.rdata ^ 32'h0000_0001;
        if (rresp_err_en && ar_addr_l == rresp_err_addr) begin
          axi.rresp = 2'b10;
          axi.rdata = axi.rdata ^ 32'h8000_0000;
        end
      end else r_wait--;
    end

    hs_aw = axi.awvalid & axi.awready; hs_awaddr = axi.awaddr;
    hs_w  = axi.wvalid & axi.wready;   hs_wdata  = axi.wdata; hs_wstrb = axi.wstrb;
    hs_b  = axi.bvalid & axi.bready;
    hs_ar = axi.arvalid & axi.arready; hs_araddr = axi.araddr;
    hs_r  = axi.rvalid & axi.rready;
    prev_awv = axi.awvalid; prev_awaddr = axi.awaddr;
    prev_wv  = axi.wvalid;  prev_wdata  = axi.wdata;
    prev_arv = axi.arvalid; prev_araddr = axi.araddr;
  endtask

  task automatic tick();
    @(negedge clk);
    slave_step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_status"}, 64'({busy, done, pass}), 64'd0);
    check({tag, "_errcnt"}, 64'(err_cnt), 64'd0);
    check({tag, "_firsterr"}, 64'(first_err), 64'd0);
    check({tag, "_valid_ready"},
          64'({axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}), 64'd0);
    check({tag, "_awaddr"}, 64'(axi.awaddr), 64'd0);
    check({tag, "_araddr"}, 64'(axi.araddr), 64'd0);
    check({tag, "_wdata"}, 64'(axi.wdata), 64'd0);
  endtask

  // Queue the expected bus traffic, pulse start for one cycle, confirm the write phase opens.
  task automatic start_run(input string tag, input logic [31:0] seed);
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    for (int i = 0; i < NW; i++) begin
      exp_aw_q.push_back(ADDR_W'(4 * i));
      exp_w_q.push_back(pat(seed, i));
      exp_ar_q.push_back(ADDR_W'(4 * i));
    end
    start   = 1'b1;
    seed_in = seed;
    tick();
    start   = 1'b0;
    check({tag, "_start_valids"}, 64'({axi.awvalid, axi.wvalid}), 64'b11);
    check({tag, "_start_busy_done"}, 64'({busy, done}), 64'b10);
  endtask

  // Wait for io_done; optionally pulse a stray start (different seed) at cycle poke_at.
  task automatic wait_done(input string tag, input int poke_at, output int lat);
    lat = 1;
    while (!done && lat < TIMEOUT) begin
      if (poke_at != 0 && lat == poke_at) begin
        start   = 1'b1;
        seed_in = ~seed_in;
      end
      tick();
      start = 1'b0;
      lat++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic check_final(input string tag, input bit exp_pass, input logic [15:0] exp_err,
                             input logic [ADDR_W-1:0] exp_first);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'(exp_pass));
    check({tag, "_errcnt"}, 64'(err_cnt), 64'(exp_err));
    check({tag, "_firsterr"}, 64'(first_err), 64'(exp_first));
    check({tag, "_hs_counts"}, 64'({8'(aw_cnt), 8'(w_cnt), 8'(b_cnt), 8'(ar_cnt), 8'(r_cnt)}),
          64'({8'd4, 8'd4, 8'd4, 8'd4, 8'd4}));
    check({tag, "_queues_left"}, 64'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()), 64'd0);
  endtask

  initial begin
    int          lat;
    int          guard;
    logic [31:0] gold [4];
    logic [31:0] rnd_seed;

    gold[0] = 32'h0000_0000; gold[1] = 32'h9E37_79B9;
    gold[2] = 32'h3C6E_F372; gold[3] = 32'hDAA6_6D2B;

    rst = 1'b1; start = 1'b0; seed_in = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 | 32'(i);

    tick();
    tick();
    check_reset_outputs("por");
    rst = 1'b0;
    tick();

    // Ideal memory, seed 0: known pattern, done 17 cycles after the start pulse.
    start_run("ideal", 32'h0);
    wait_done("ideal", 0, lat);
    check("ideal_latency", 64'(lat), 64'd17);
    check_final("ideal", 1'b1, 16'd0, '0);
    for (int i = 0; i < 4; i++) check("ideal_mem", 64'(mem[i]), 64'(gold[i]));

    // Single corrupted read at 0x8; started straight out of DONE.
    corrupt_en = 1; corrupt_addr = 24'h8;
    start_run("corrupt", 32'h0);
    wait_done("corrupt", 0, lat);
    check_final("corrupt", 1'b0, 16'd1, 24'h8);
    corrupt_en = 0;

    // Write response error at 0x4 and read response error plus bad data at 0xC.
    bresp_err_en = 1; bresp_err_addr = 24'h4;
    rresp_err_en = 1; rresp_err_addr = 24'hC;
    start_run("resp_err", 32'h0);
    wait_done("resp_err", 0, lat);
    check_final("resp_err", 1'b0, 16'd2, 24'h4);
    bresp_err_en = 0; rresp_err_en = 0;

    // Random stalls on every slave-driven handshake signal.
    stall_en = 1;
    for (int k = 0; k < 3; k++) begin
      rnd_seed = $urandom;
      start_run("stall", rnd_seed);
      wait_done("stall", 0, lat);
      check_final("stall", 1'b1, 16'd0, '0);
      for (int i = 0; i < 4; i++) check("stall_mem", 64'(mem[i]), 64'(pat(rnd_seed, i)));
    end
    stall_en = 0;

    // Stray start while busy must not restart or alter the run.
    start_run("busy_start", 32'hCAFE_F00D);
    wait_done("busy_start", 6, lat);
    check("busy_start_latency", 64'(lat), 64'd17);
    check_final("busy_start", 1'b1, 16'd0, '0);

    // Reset while waiting for read data of word 2.
    start_run("mid_rst", 32'h5555_AAAA);
    guard = 0;
    while (!(axi.rready && axi.araddr == 24'h8) && guard < TIMEOUT) begin
      tick();
      guard++;
    end
    check("mid_rst_reached_rdata2", 64'(axi.rready && axi.araddr == 24'h8), 64'd1);
    rst = 1'b1;
    tick();
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
    tick();
    check_reset_outputs("post_rst_idle");

    start_run("after_rst", 32'h1234_5678);
    wait_done("after_rst", 0, lat);
    check("after_rst_latency", 64'(lat), 64'd17);
    check_final("after_rst", 1'b1, 16'd0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
